// File: rtl/hid_bus_arbiter.sv
// Two-master round-robin arbiter for the peripheral hid_* bus, with read-return routing.
// Define HID_ARB_LOCK_EN to add the mX_lock ports and the bounded bus-lock counter.
module hid_bus_arbiter #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 64,
    parameter int BE_W     = 8,
    parameter int READ_LAT = 1,
    parameter int LOCK_MAX = 16
) (
    input  logic              msoc_clk,
    input  logic              rstn,
    input  logic              m0_req,
    input  logic [BE_W-1:0]   m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wrdata,
    input  logic              m1_req,
    input  logic [BE_W-1:0]   m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wrdata,
`ifdef HID_ARB_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rddata,
    output logic [DATA_W-1:0] m1_rddata,
    output logic              hid_en,
    output logic [BE_W-1:0]   hid_we,
    output logic [ADDR_W-1:0] hid_addr,
    output logic [DATA_W-1:0] hid_wrdata,
    input  logic [DATA_W-1:0] hid_rddata
);

    logic              ptr_q, ptr_d;
    logic              pref;
    logic              hs;
    logic              winner;
    logic [BE_W-1:0]   selWe;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWrdata;
    logic              isRead;

    logic              hidEn_q;
    logic [BE_W-1:0]   hidWe_q;
    logic [ADDR_W-1:0] hidAddr_q;
    logic [DATA_W-1:0] hidWrdata_q;

    logic [READ_LAT-1:0] trkValid_q;
    logic [READ_LAT-1:0] trkOwner_q;
    logic                rvalid0_q, rvalid1_q;

`ifdef HID_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    logic [CNT_W-1:0] lockCnt_q, lockCnt_d;
    logic             selLock;
    logic             lockExpired;

    // Once the locked master has used its quota, the other master becomes preferred.
    assign lockExpired = (lockCnt_q == CNT_W'(LOCK_MAX));
    assign pref        = lockExpired ? ~ptr_q : ptr_q;
    assign selLock     = winner ? m1_lock : m0_lock;
`else
    assign pref = ptr_q;
`endif

    // Grants are gated by rstn so nothing is granted while the block is held in reset.
    always_comb begin
        m0_gnt = rstn & m0_req & (~m1_req | ~pref);
        m1_gnt = rstn & m1_req & (~m0_req | pref);
    end

    assign hs        = m0_gnt | m1_gnt;
    assign winner    = m1_gnt;
    assign selWe     = winner ? m1_we     : m0_we;
    assign selAddr   = winner ? m1_addr   : m0_addr;
    assign selWrdata = winner ? m1_wrdata : m0_wrdata;
    assign isRead    = (selWe == '0);

    always_comb begin
        ptr_d = ptr_q;
`ifdef HID_ARB_LOCK_EN
        lockCnt_d = lockCnt_q;
        if (hs) begin
            if (selLock) begin
                ptr_d = winner;
                if (winner != ptr_q) begin
                    lockCnt_d = CNT_W'(1);
                end else if (!lockExpired) begin
                    lockCnt_d = lockCnt_q + CNT_W'(1);
                end
            end else begin
                ptr_d     = ~winner;
                lockCnt_d = '0;
            end
        end
`else
        if (hs) begin
            ptr_d = ~winner;
        end
`endif
    end

    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q       <= 1'b0;
            hidEn_q     <= 1'b0;
            hidWe_q     <= '0;
            hidAddr_q   <= '0;
            hidWrdata_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            hidEn_q <= hs;
            hidWe_q <= hs ? selWe : '0;
            if (hs) begin
                hidAddr_q   <= selAddr;
                hidWrdata_q <= selWrdata;
            end
        end
    end

`ifdef HID_ARB_LOCK_EN
    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            lockCnt_q <= '0;
        end else begin
            lockCnt_q <= lockCnt_d;
        end
    end
`endif

    // Stage 0 lines up with hid_en; the tail entry becomes rvalid one cycle after it
    // leaves the pipe, which is when the peripheral's read data is valid.
    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            trkValid_q <= '0;
            trkOwner_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            trkValid_q[0] <= hs & isRead;
            trkOwner_q[0] <= winner;
            for (int i = 1; i < READ_LAT; i++) begin
                trkValid_q[i] <= trkValid_q[i-1];
                trkOwner_q[i] <= trkOwner_q[i-1];
            end
            rvalid0_q <= trkValid_q[READ_LAT-1] & ~trkOwner_q[READ_LAT-1];
            rvalid1_q <= trkValid_q[READ_LAT-1] &  trkOwner_q[READ_LAT-1];
        end
    end

    assign hid_en     = hidEn_q;
    assign hid_we     = hidWe_q;
    assign hid_addr   = hidAddr_q;
    assign hid_wrdata = hidWrdata_q;
    assign m0_rvalid  = rvalid0_q;
    assign m1_rvalid  = rvalid1_q;
    assign m0_rddata  = hid_rddata;
    assign m1_rddata  = hid_rddata;

endmodule

// File: tb/tb_hid_bus_arbiter.sv
// Self-checking bench: two arbiters (READ_LAT 1 and 3) share stimulus and are compared
// against a cycle-level reference model with response queues.
module tb_hid_bus_arbiter;

    localparam int ADDR_W   = 18;
    localparam int DATA_W   = 64;
    localparam int BE_W     = 8;
    localparam int LOCK_MAX = 16;
`ifdef HID_ARB_LOCK_EN
    localparam bit LOCKEN = 1'b1;
`else
    localparam bit LOCKEN = 1'b0;
`endif

    typedef struct {
        int due;
        bit owner;
    } resp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic              mReq[2];
    logic [BE_W-1:0]   mWe[2];
    logic [ADDR_W-1:0] mAddr[2];
    logic [DATA_W-1:0] mWr[2];
    logic              mLock[2];
    logic [DATA_W-1:0] hidRd;

    logic              aGnt[2], aRv[2], bGnt[2], bRv[2];
    logic [DATA_W-1:0] aRd[2], bRd[2];
    logic              aEn, bEn;
    logic [BE_W-1:0]   aWe, bWe;
    logic [ADDR_W-1:0] aAddr, bAddr;
    logic [DATA_W-1:0] aWr, bWr;

    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    bit  mPtr;
    int  lockCnt;
    bit  lockOwner;
    bit  expEn;
    logic [BE_W-1:0]   expWe;
    logic [ADDR_W-1:0] expAddr;
    logic [DATA_W-1:0] expWr;
    resp_t qA[$];
    resp_t qB[$];
    bit  lastG[2];
    bit  randMode = 1'b0;
    bit  keepReq  = 1'b0;

    hid_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .READ_LAT(1), .LOCK_MAX(LOCK_MAX)) dutA (
        .msoc_clk(clk), .rstn(rstn),
        .m0_req(mReq[0]), .m0_we(mWe[0]), .m0_addr(mAddr[0]), .m0_wrdata(mWr[0]),
        .m1_req(mReq[1]), .m1_we(mWe[1]), .m1_addr(mAddr[1]), .m1_wrdata(mWr[1]),
`ifdef HID_ARB_LOCK_EN
        .m0_lock(mLock[0]), .m1_lock(mLock[1]),
`endif
        .m0_gnt(aGnt[0]), .m1_gnt(aGnt[1]), .m0_rvalid(aRv[0]), .m1_rvalid(aRv[1]),
        .m0_rddata(aRd[0]), .m1_rddata(aRd[1]),
        .hid_en(aEn), .hid_we(aWe), .hid_addr(aAddr), .hid_wrdata(aWr), .hid_rddata(hidRd)
    );

    hid_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .READ_LAT(3), .LOCK_MAX(LOCK_MAX)) dutB (
        .msoc_clk(clk), .rstn(rstn),
        .m0_req(mReq[0]), .m0_we(mWe[0]), .m0_addr(mAddr[0]), .m0_wrdata(mWr[0]),
        .m1_req(mReq[1]), .m1_we(mWe[1]), .m1_addr(mAddr[1]), .m1_wrdata(mWr[1]),
`ifdef HID_ARB_LOCK_EN
        .m0_lock(mLock[0]), .m1_lock(mLock[1]),
`endif
        .m0_gnt(bGnt[0]), .m1_gnt(bGnt[1]), .m0_rvalid(bRv[0]), .m1_rvalid(bRv[1]),
        .m0_rddata(bRd[0]), .m1_rddata(bRd[1]),
        .hid_en(bEn), .hid_we(bWe), .hid_addr(bAddr), .hid_wrdata(bWr), .hid_rddata(hidRd)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic newReq(input int i);
        mReq[i]  = ($urandom_range(0, 3) != 0);
        mWe[i]   = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom);
        mAddr[i] = 18'($urandom);
        mWr[i]   = {$urandom, $urandom};
        mLock[i] = ($urandom_range(0, 3) == 0);
    endtask

    task automatic modelReset();
        mPtr = 1'b0; lockCnt = 0; lockOwner = 1'b0;
        expEn = 1'b0; expWe = '0; expAddr = '0; expWr = '0;
        qA.delete(); qB.delete();
        lastG[0] = 1'b0; lastG[1] = 1'b0;
    endtask

    task automatic doReset();
        rstn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mReq[i] = 1'b0; mWe[i] = '0; mAddr[i] = '0; mWr[i] = '0; mLock[i] = 1'b0;
        end
        modelReset();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // One clock cycle: check the current cycle against the model, predict the next one,
    // then advance and let the masters react to the grant.
    task automatic applyStimulus();
        resp_t r;
        bit    ev0, ev1, any, w;
        @(negedge clk);
        chk("a_hid_en", aEn, expEn);
        chk("a_hid_we", aWe, expWe);
        chk("a_hid_addr", aAddr, expAddr);
        chk("a_hid_wrdata", aWr, expWr);
        chk("b_hid_en", bEn, expEn);
        chk("b_hid_addr", bAddr, expAddr);

        ev0 = 1'b0; ev1 = 1'b0;
        if (qA.size() > 0 && qA[0].due == cyc) begin
            r = qA.pop_front();
            if (r.owner) ev1 = 1'b1; else ev0 = 1'b1;
        end
        chk("a_rvalid0", aRv[0], ev0);
        chk("a_rvalid1", aRv[1], ev1);
        if (ev0) chk("a_rddata0", aRd[0], hidRd);
        if (ev1) chk("a_rddata1", aRd[1], hidRd);

        ev0 = 1'b0; ev1 = 1'b0;
        if (qB.size() > 0 && qB[0].due == cyc) begin
            r = qB.pop_front();
            if (r.owner) ev1 = 1'b1; else ev0 = 1'b1;
        end
        chk("b_rvalid0", bRv[0], ev0);
        chk("b_rvalid1", bRv[1], ev1);
        if (ev0) chk("b_rddata0", bRd[0], hidRd);

        any = mReq[0] | mReq[1];
        if (mReq[0] && mReq[1]) w = (lockCnt >= LOCK_MAX) ? !lockOwner : mPtr;
        else                    w = mReq[1];
        lastG[0] = any && !w;
        lastG[1] = any && w;
        chk("a_gnt0", aGnt[0], lastG[0]);
        chk("a_gnt1", aGnt[1], lastG[1]);
        chk("b_gnt0", bGnt[0], lastG[0]);
        chk("b_gnt1", bGnt[1], lastG[1]);

        if (any) begin
            expEn = 1'b1; expWe = mWe[w]; expAddr = mAddr[w]; expWr = mWr[w];
            if (mWe[w] == '0) begin
                qA.push_back('{due: cyc + 2, owner: w});
                qB.push_back('{due: cyc + 4, owner: w});
            end
            if (LOCKEN && mLock[w]) begin
                lockCnt   = (w == lockOwner && lockCnt > 0) ? ((lockCnt < LOCK_MAX) ? lockCnt + 1 : LOCK_MAX) : 1;
                lockOwner = w;
                mPtr      = w;
            end else begin
                lockCnt = 0;
                mPtr    = !w;
            end
        end else begin
            expEn = 1'b0; expWe = '0;
        end

        @(posedge clk);
        cyc++;
        #1;
        hidRd = {$urandom, $urandom};
        for (int i = 0; i < 2; i++) begin
            if (randMode) begin
                if (lastG[i] || !mReq[i]) newReq(i);
            end else if (lastG[i] && !keepReq) begin
                mReq[i] = 1'b0;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, "_en"}, aEn, 0);
        chk({tag, "_we"}, aWe, 0);
        chk({tag, "_addr"}, aAddr, 0);
        chk({tag, "_wrdata"}, aWr, 0);
        chk({tag, "_gnt0"}, aGnt[0], 0);
        chk({tag, "_gnt1"}, aGnt[1], 0);
        chk({tag, "_rvalid0"}, aRv[0], 0);
        chk({tag, "_rvalid1"}, bRv[1], 0);
    endtask

    initial begin
        int pulses, pulseCyc, readCyc;
        hidRd = '0;
        doReset();
        #1 checkOutput("reset");

        // Single read from m0
        mReq[0] = 1'b1; mWe[0] = '0; mAddr[0] = 18'h08000; mWr[0] = '0;
        #1 chk("sr_gnt0_edge0", aGnt[0], 1);
        applyStimulus();
        #1 chk("sr_hid_en", aEn, 1);
        chk("sr_hid_addr", aAddr, 18'h08000);
        chk("sr_hid_we", aWe, 0);
        applyStimulus();
        hidRd = 64'hDEADBEEF;
        #1 chk("sr_rvalid0", aRv[0], 1);
        chk("sr_rddata0", aRd[0], 64'hDEADBEEF);
        chk("sr_rvalid1", aRv[1], 0);
        repeat (4) applyStimulus();

        // Contention: both masters read continuously right after reset
        doReset();
        keepReq = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mReq[i] = 1'b1; mWe[i] = '0; mAddr[i] = 18'(32'h100 * (i + 1)); mWr[i] = '0;
        end
        for (int k = 0; k < 6; k++) begin
            #1 chk("cont_gnt_winner", (k % 2 == 0) ? aGnt[0] : aGnt[1], 1);
            chk("cont_gnt_loser", (k % 2 == 0) ? aGnt[1] : aGnt[0], 0);
            applyStimulus();
            #1 chk("cont_hid_en", aEn, 1);
            if (k + 1 == 4) chk("lat3_first_rvalid0", bRv[0], 1);
            if (k + 1 == 5) chk("lat3_second_rvalid1", bRv[1], 1);
        end
        keepReq = 1'b0;
        mReq[0] = 1'b0; mReq[1] = 1'b0;
        repeat (5) applyStimulus();

        // Mixed: m1 write followed back-to-back by a read
        doReset();
        mReq[1] = 1'b1; mWe[1] = 8'hFF; mAddr[1] = 18'h10000; mWr[1] = 64'h0123456789ABCDEF;
        applyStimulus();
        mReq[1] = 1'b1; mWe[1] = 8'h00; mAddr[1] = 18'h10008;
        readCyc = cyc;
        pulses = 0; pulseCyc = -1;
        applyStimulus();
        for (int k = 0; k < 5; k++) begin
            #1 if (aRv[1]) begin pulses++; pulseCyc = cyc; end
            applyStimulus();
        end
        chk("mix_rvalid_pulses", pulses, 1);
        chk("mix_rvalid_cycle", pulseCyc, readCyc + 2);

`ifdef HID_ARB_LOCK_EN
        // Lock: m0 locks while m1 keeps requesting
        doReset();
        keepReq = 1'b1;
        mReq[0] = 1'b1; mWe[0] = 8'h01; mAddr[0] = 18'h00040; mLock[0] = 1'b1;
        mReq[1] = 1'b1; mWe[1] = 8'h01; mAddr[1] = 18'h00080; mLock[1] = 1'b0;
        for (int k = 0; k <= LOCK_MAX; k++) begin
            #1 chk("lock_gnt0", aGnt[0], (k < LOCK_MAX) ? 1 : 0);
            chk("lock_gnt1", aGnt[1], (k < LOCK_MAX) ? 0 : 1);
            applyStimulus();
        end
        keepReq = 1'b0;
        mReq[0] = 1'b0; mReq[1] = 1'b0; mLock[0] = 1'b0;
        repeat (3) applyStimulus();
`endif

        // Randomized traffic
        doReset();
        randMode = 1'b1;
        newReq(0); newReq(1);
        repeat (600) applyStimulus();
        randMode = 1'b0;

        // Reset in the cycle after a read grant
        mReq[0] = 1'b1; mWe[0] = '0; mAddr[0] = 18'h0ABCD;
        mReq[1] = 1'b0;
        applyStimulus();
        mReq[0] = 1'b1; mReq[1] = 1'b1; mWe[1] = '0; mAddr[1] = 18'h00123;
        #1 rstn = 1'b0;
        #1 checkOutput("midrst");
        modelReset();
        @(posedge clk);
        #1 rstn = 1'b1;
        #1 chk("midrst_gnt0", aGnt[0], 1);
        chk("midrst_gnt1", aGnt[1], 0);
        keepReq = 1'b0;
        applyStimulus();
        mReq[0] = 1'b0; mReq[1] = 1'b0;
        repeat (6) applyStimulus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hid_bus_arbiter.md
# hid_bus_arbiter

Two-master arbiter for the peripheral `hid_*` bus that feeds the SoC peripheral block (RAM, SD buffer, UART/keyboard, ethernet framing, frame store). Master 0 is the core LSU port and master 1 is the debug/boot loader. The block grants single-beat requests round-robin and registers the winning request onto `hid_*`. It tracks outstanding reads so each read's `hid_rddata` returns to the master that issued it.

## Interface
- `ADDR_W`, 18: address width, matches `hid_addr`.
- `DATA_W`, 64: data width.
- `BE_W`, 8: byte-enable width; must equal `DATA_W/8`.
- `READ_LAT`, 1: cycles from `hid_en` high to valid `hid_rddata`; legal range 1..3.
- `LOCK_MAX`, 16: maximum consecutive locked grants; used only with `HID_ARB_LOCK_EN`.
- `msoc_clk`, in, 1: the only clock.
- `rstn`, in, 1: asynchronous, active-low reset.
- `m0_req` / `m1_req`, in, 1: request valid; held until granted.
- `m0_we` / `m1_we`, in, `BE_W`: byte write enables; all-zero marks a read.
- `m0_addr` / `m1_addr`, in, `ADDR_W`: request address.
- `m0_wrdata` / `m1_wrdata`, in, `DATA_W`: write data.
- `m0_lock` / `m1_lock`, in, 1: hold the bus after this grant; exists only with `HID_ARB_LOCK_EN`.
- `m0_gnt` / `m1_gnt`, out, 1: request accepted at this rising edge.
- `m0_rvalid` / `m1_rvalid`, out, 1: read data valid this cycle.
- `m0_rddata` / `m1_rddata`, out, `DATA_W`: read data; equals `hid_rddata`, qualified by the matching `rvalid`.
- `hid_en`, out, 1: registered strobe, one cycle per transaction.
- `hid_we`, out, `BE_W`: registered byte enables.
- `hid_addr`, out, `ADDR_W`: registered address.
- `hid_wrdata`, out, `DATA_W`: registered write data.
- `hid_rddata`, in, `DATA_W`: peripheral read mux output.

## Operation
- **Grant logic.** Grant is combinational from `mX_req` and the priority pointer `ptr`. At most one `gnt` is high per cycle. A handshake completes at a rising edge where `req & gnt` are both high.
- **Pointer.** `ptr` names the preferred master.
  - Both requesting: grant `ptr`.
  - One requesting: grant that master regardless of `ptr`.
  - After every grant, `ptr` moves to the other master (unless locked; see Configuration).
- **Issue register.** On a handshake the master's `we`/`addr`/`wrdata` load into the `hid_*` registers and `hid_en` is 1 for the next cycle.
- **Idle.** With no handshake, `hid_en` and `hid_we` are 0. `hid_addr` and `hid_wrdata` hold their last values.
- **Throughput.** One transaction per cycle, with no bubble between back-to-back grants.
- **Read tracking.** A `READ_LAT`-deep shift register holds `{valid, owner}` for each issued transaction. Valid is set only for reads (`we==0`). Writes are posted and produce no `rvalid`.
- **Read return.** When a tracked entry reaches the pipeline tail, the owner's `rvalid` is high for exactly one cycle. Read responses return in issue order.
- **Reset values.** `hid_en`=0, `hid_we`=0, `hid_addr`=0, `hid_wrdata`=0, `gnt`=0, `rvalid`=0, `ptr`=master 0, lock counter=0, tracking pipeline cleared.
- **Reset mid-operation.** Asserting `rstn` low clears all state asynchronously. In-flight reads are dropped and no `rvalid` is ever emitted for them.

## Timing
- **Handshake at edge t:** `hid_*` valid in cycle t+1, and `rvalid` to the owner in cycle t+1+`READ_LAT`.
- **Default `READ_LAT`=1:** a read granted at edge t returns `rvalid` in cycle t+2.
- **Simultaneous events:** a new grant and a `rvalid` for an older read may occur in the same cycle, to the same or different masters.
- **Requirements on masters:**
  - A master keeps `req` and its fields stable until `gnt`.
  - A master may deassert `req` only after the handshake.
  - `gnt` is never asserted without `req`.

## Configuration
- **`HID_ARB_LOCK_EN` defined:**
  - The `mX_lock` ports exist.
  - A handshake with `lock`=1 keeps `ptr` on that master and increments the lock counter.
  - Once the counter reaches `LOCK_MAX`, the next grant that sees the other master requesting goes to the other master. The counter then clears and normal alternation resumes.
  - A handshake with `lock`=0, or a grant to the other master, clears the counter.
  - The locked master still loses to nobody while it is requesting, up to the `LOCK_MAX` limit.
- **`HID_ARB_LOCK_EN` undefined:** the `mX_lock` ports and the lock counter are absent, and arbitration is pure round-robin.

## Test plan
- **Single read.** m0 alone reads addr 0x08000. Required: `m0_gnt` at edge 0, `hid_en`=1 with `hid_addr`=0x08000 and `hid_we`=0 in cycle 1, `m0_rvalid` in cycle 2 carrying `hid_rddata` (e.g. 0xDEADBEEF), `m1_rvalid` stays 0.
- **Contention.** m0 and m1 both request continuously for 6 cycles after reset. Required: grants go m0,m1,m0,m1,m0,m1, and `hid_en` is high every cycle from cycle 1.
- **Mixed read/write.** m1 writes `we`=0xFF to 0x10000, then reads 0x10008 back-to-back. Required: exactly one `m1_rvalid` pulse, two cycles after the read grant, and none for the write.
- **Latency parameter.** With `READ_LAT`=3, m0 and m1 issue interleaved reads. Required: each `rvalid` lands 4 cycles after its grant, on the correct master, in order.
- **Lock.** With `HID_ARB_LOCK_EN`, `LOCK_MAX`=16, m0 requests with `lock`=1 while m1 also requests. Required: 16 consecutive `m0_gnt`, then `m1_gnt` on the next grant.
- **Reset mid-operation.** Drop `rstn` in the cycle after a read grant. Required: all outputs 0 immediately, no `rvalid` after release, and the next contended grant goes to m0.
